id_ex_hazard_reg: RTL and testbench
===================================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection. Latches the
//  decoded operands, the 32-bit sign-extended immediate and control from decode,
//  and presents them to execute. Detects lw-use dependencies, stalls PC and IF/ID
//  one cycle, inserts a bubble, and applies flush/hold from later stages.
// PARAMETERS
//  DATA_W  32  width of operand, immediate and PC+4 fields
//  REG_AW   5  register-specifier width
//  ALUOP_W  4  width of ALU control field
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        async active-low reset
//  id_valid       in   1        decode slot holds a real instruction
//  id_pc4         in   DATA_W   PC+4 of decode instruction
//  id_rd1/id_rd2  in   DATA_W   register-file read data (rs, rt)
//  id_imm         in   DATA_W   sign-extended immediate
//  id_rs/id_rt/id_rd in REG_AW  register specifiers
//  id_uses_rt     in   1        instruction reads rt as a source
//  id_alu_op      in   ALUOP_W  ALU control
//  id_alu_src/id_reg_dst/id_mem_read/id_mem_write/id_reg_write/id_mem_to_reg in 1 ctrl
//  ex_flush       in   1        squash ID/EX (taken branch/jump resolved)
//  ex_hold        in   1        execute busy; freeze ID/EX
//  stall_if_id    out  1        hold PC and IF/ID this cycle (combinational)
//  ex_valid       out  1        execute slot holds a real instruction
//  ex_pc4/ex_rd1/ex_rd2/ex_imm out DATA_W  registered copies
//  ex_rs/ex_rt/ex_rd out REG_AW registered copies
//  ex_alu_op + six ex_* ctrl bits out  registered copies
// BEHAVIOUR
//  - Reset (async, rst_n=0): every ex_* output, ex_valid = 0; held until first edge after release.
//  - Hazard (comb): haz = ex_valid & ex_mem_read & id_valid & (ex_rt!=0) &
//    (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  - stall_if_id = ~ex_flush & (ex_hold | haz).
//  - Per-edge priority, highest first:
//    1 ex_flush: load bubble (ex_valid=0, all ctrl bits 0, data/specifier fields 0).
//    2 ex_hold : all ex_* registers keep value.
//    3 haz     : load bubble as in 1.
//    4 else    : load all id_* fields; ex_valid <= id_valid; if id_valid=0, ctrl bits forced 0.
//  - Latency: 1 cycle ID->EX. Load-use costs exactly one bubble; after the bubble
//    ex_mem_read=0 so haz drops and the stalled instruction advances next edge.
//  - Bubble/invalid slot never asserts ex_reg_write, ex_mem_write or ex_mem_read.
//  - $zero: ex_rt==0 never raises haz.
//  - Flush + haz same cycle: flush wins, stall_if_id=0 (upstream refetches anyway).
//  - Hold + haz: held; stall stays high; haz re-evaluated each cycle.
//  - Reset mid-stall: stall_if_id drops immediately since ex_valid=0.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds out ports bubble_cnt[31:0], flush_cnt[31:0];
//    bubble_cnt +1 on each edge taking priority 3, flush_cnt +1 on each edge with
//    ex_flush=1; both wrap 0xFFFFFFFF->0; async reset to 0; frozen by nothing else.
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 ex lw rt=5 valid, id rs=5 valid -> stall_if_id=1 one cycle, next ex_valid=0 &
//    ctrl=0; following edge ex_rs=5, ex_imm=id_imm, stall_if_id=0.
//  2 ex lw rt=0, id rs=0 -> stall_if_id=0, instruction loads directly.
//  3 ex lw rt=7, id rt=7 with id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
//  4 haz + ex_flush same cycle -> stall_if_id=0, bubble loaded, ex_reg_write=0.
//  5 ex_hold=1 three cycles with id_imm=0xFFFF8000 -> ex_* frozen, stall=1;
//    release -> ex_imm=0xFFFF8000 next edge.
//  6 rst_n low during stall -> all ex_* =0 immediately; with HAZ_PERF_CNT_EN
//    counters=0; bubble_cnt preset 0xFFFFFFFF + one bubble -> 0.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush/hold.
// Optional `HAZ_PERF_CNT_EN adds bubble/flush event counters.
module id_ex_hazard_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [DATA_W-1:0]  id_rd1,
  input  logic [DATA_W-1:0]  id_rd2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rt,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic               ex_flush,
  input  logic               ex_hold,
  output logic               stall_if_id,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rd1,
  output logic [DATA_W-1:0]  ex_rd2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0]  pc4;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
  } idex_t;

  idex_t      id_load, ex_q;
  logic [1:0] vld_pipe;
  logic       haz;

  assign vld_pipe[0] = id_valid;

  // An invalid decode slot still carries its data, but must never issue side effects.
  always_comb begin
    id_load = '{pc4: id_pc4, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
                rs: id_rs, rt: id_rt, rd: id_rd, alu_op: id_alu_op,
                alu_src: id_alu_src, reg_dst: id_reg_dst, mem_read: id_mem_read,
                mem_write: id_mem_write, reg_write: id_reg_write,
                mem_to_reg: id_mem_to_reg};
    if (!id_valid) begin
      id_load.alu_op     = '0;
      id_load.alu_src    = 1'b0;
      id_load.reg_dst    = 1'b0;
      id_load.mem_read   = 1'b0;
      id_load.mem_write  = 1'b0;
      id_load.reg_write  = 1'b0;
      id_load.mem_to_reg = 1'b0;
    end
  end

  assign haz = vld_pipe[1] & ex_q.mem_read & id_valid & (ex_q.rt != '0) &
               ((ex_q.rt == id_rs) | (id_uses_rt & (ex_q.rt == id_rt)));

  // Flush overrides the stall: upstream is being redirected anyway.
  assign stall_if_id = ~ex_flush & (ex_hold | haz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      vld_pipe[1] <= 1'b0;
    end else if (ex_flush) begin
      ex_q        <= '0;
      vld_pipe[1] <= 1'b0;
    end else if (ex_hold) begin
      ex_q        <= ex_q;
      vld_pipe[1] <= vld_pipe[1];
    end else if (haz) begin
      ex_q        <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      ex_q        <= id_load;
      vld_pipe[1] <= vld_pipe[0];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!ex_flush && !ex_hold && haz) bubble_cnt <= bubble_cnt + 32'd1;
      if (ex_flush)                     flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

  assign ex_valid      = vld_pipe[1];
  assign ex_pc4        = ex_q.pc4;
  assign ex_rd1        = ex_q.rd1;
  assign ex_rd2        = ex_q.rd2;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed vector table, hold/reset sequences, random vs. reference model.
module tb_id_ex_hazard_reg;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid, id_uses_rt, id_alu_src, id_reg_dst, id_mem_read, id_mem_write;
  logic        id_reg_write, id_mem_to_reg, ex_flush, ex_hold;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_op;
  logic        stall_if_id, ex_valid, ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  ex_alu_op;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
  logic [31:0] m_bub, m_fl;
`endif

  int n_chk = 0, n_pass = 0;

  id_ex_hazard_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg)
`ifdef HAZ_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  alu_op;
    logic        alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg;
  } ex_t;

  typedef struct {
    logic vld; logic [4:0] rs, rt; logic urt, mrd, rwr; logic [31:0] imm; logic fl, ho;
    logic st, ev; logic [4:0] ers, ert; logic emrd, erwr; logic [31:0] eimm;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic ex_t dut_ex();
    return '{ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op,
             ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg};
  endfunction

  task automatic drive(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mrd, input logic rwr,
                       input logic [31:0] imm, input logic fl, input logic ho);
    id_valid = vld; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_mem_read = mrd;
    id_reg_write = rwr; id_imm = imm; ex_flush = fl; ex_hold = ho;
    id_pc4 = imm + 32'd4; id_rd1 = {27'h5a5a5a, rs}; id_rd2 = {27'h3c3c3c, rt};
    id_rd = 5'd10; id_alu_op = 4'h3; id_alu_src = mrd; id_reg_dst = ~mrd;
    id_mem_write = 1'b0; id_mem_to_reg = mrd;
  endtask

  // Reference: next execute slot from the stage-to-stage rules, not from the RTL structure.
  ex_t m;
  function automatic logic ref_haz(input ex_t e);
    return e.valid && e.mem_read && id_valid && e.rt != 0 &&
           (e.rt == id_rs || (id_uses_rt && e.rt == id_rt));
  endfunction
  function automatic ex_t ref_next(input ex_t e);
    ex_t nx;
    if (ex_flush)     nx = '0;
    else if (ex_hold) nx = e;
    else if (ref_haz(e)) nx = '0;
    else begin
      nx = '{id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_alu_op,
             id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg};
      if (!id_valid) {nx.alu_op, nx.alu_src, nx.reg_dst, nx.mem_read, nx.mem_write,
                      nx.reg_write, nx.mem_to_reg} = '0;
    end
    return nx;
  endfunction

  vec_t vt[12];

  initial begin
    vt[0]  = '{1'b1,5'd1,5'd5,1'b0,1'b1,1'b1,32'h10,1'b0,1'b0, 1'b0,1'b1,5'd1,5'd5,1'b1,1'b1,32'h10};
    vt[1]  = '{1'b1,5'd5,5'd2,1'b1,1'b0,1'b1,32'h20,1'b0,1'b0, 1'b1,1'b0,5'd0,5'd0,1'b0,1'b0,32'h0};
    vt[2]  = '{1'b1,5'd5,5'd2,1'b1,1'b0,1'b1,32'h20,1'b0,1'b0, 1'b0,1'b1,5'd5,5'd2,1'b0,1'b1,32'h20};
    vt[3]  = '{1'b1,5'd3,5'd0,1'b0,1'b1,1'b1,32'h30,1'b0,1'b0, 1'b0,1'b1,5'd3,5'd0,1'b1,1'b1,32'h30};
    vt[4]  = '{1'b1,5'd0,5'd4,1'b1,1'b0,1'b1,32'h40,1'b0,1'b0, 1'b0,1'b1,5'd0,5'd4,1'b0,1'b1,32'h40};
    vt[5]  = '{1'b1,5'd1,5'd7,1'b0,1'b1,1'b1,32'h50,1'b0,1'b0, 1'b0,1'b1,5'd1,5'd7,1'b1,1'b1,32'h50};
    vt[6]  = '{1'b1,5'd2,5'd7,1'b0,1'b0,1'b1,32'h60,1'b0,1'b0, 1'b0,1'b1,5'd2,5'd7,1'b0,1'b1,32'h60};
    vt[7]  = '{1'b1,5'd1,5'd7,1'b0,1'b1,1'b1,32'h70,1'b0,1'b0, 1'b0,1'b1,5'd1,5'd7,1'b1,1'b1,32'h70};
    vt[8]  = '{1'b1,5'd2,5'd7,1'b1,1'b0,1'b1,32'h80,1'b0,1'b0, 1'b1,1'b0,5'd0,5'd0,1'b0,1'b0,32'h0};
    vt[9]  = '{1'b1,5'd1,5'd6,1'b0,1'b1,1'b1,32'h90,1'b0,1'b0, 1'b0,1'b1,5'd1,5'd6,1'b1,1'b1,32'h90};
    vt[10] = '{1'b1,5'd6,5'd0,1'b0,1'b0,1'b1,32'ha0,1'b1,1'b0, 1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,32'h0};
    vt[11] = '{1'b0,5'd9,5'd9,1'b0,1'b1,1'b1,32'hb0,1'b0,1'b0, 1'b0,1'b0,5'd9,5'd9,1'b0,1'b0,32'hb0};

    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 32'hdead, 1'b0, 1'b0);
    #12;
    check("reset_state", 256'(dut_ex()), 256'(ex_t'('0)));
    check("reset_stall", 256'(stall_if_id), 256'(1'b0));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].vld, vt[i].rs, vt[i].rt, vt[i].urt, vt[i].mrd, vt[i].rwr, vt[i].imm,
            vt[i].fl, vt[i].ho);
      #1;
      check($sformatf("vec%0d_stall", i), 256'(stall_if_id), 256'(vt[i].st));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ex", i),
            256'({ex_valid, ex_rs, ex_rt, ex_mem_read, ex_reg_write, ex_imm, ex_mem_write}),
            256'({vt[i].ev, vt[i].ers, vt[i].ert, vt[i].emrd, vt[i].erwr, vt[i].eimm, 1'b0}));
      @(negedge clk);
    end

    // Hold freezes the slot for three cycles; release loads the waiting immediate.
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 32'hffff8000, 1'b0, 1'b1);
      #1 check($sformatf("hold%0d_stall", c), 256'(stall_if_id), 256'(1'b1));
      @(posedge clk); #1;
      check($sformatf("hold%0d_ex", c), 256'({ex_valid, ex_imm, ex_rs}), 256'({1'b1, 32'h11, 5'd1}));
      @(negedge clk);
    end
    ex_hold = 1'b0;
    #1 check("release_stall", 256'(stall_if_id), 256'(1'b0));
    @(posedge clk); #1;
    check("release_ex", 256'({ex_valid, ex_imm, ex_rs}), 256'({1'b1, 32'hffff8000, 5'd3}));
    @(negedge clk);

    // Reset arriving during a load-use stall clears everything at once.
    drive(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    drive(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 32'h48, 1'b0, 1'b0);
    #1 check("pre_reset_stall", 256'(stall_if_id), 256'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_stall", 256'(stall_if_id), 256'(1'b0));
    check("mid_reset_ex", 256'(dut_ex()), 256'(ex_t'('0)));
    @(negedge clk); rst_n = 1'b1;

    m = '0;
`ifdef HAZ_PERF_CNT_EN
    m_bub = 0; m_fl = 0;
    check("cnt_reset", 256'({bubble_cnt, flush_cnt}), 256'(64'h0));
`endif
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), $urandom,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0));
      id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_rd = 5'($urandom);
      id_alu_op = 4'($urandom); id_mem_write = 1'($urandom); id_alu_src = 1'($urandom);
      #1;
      check("rnd_stall", 256'(stall_if_id), 256'(!ex_flush && (ex_hold || ref_haz(m))));
`ifdef HAZ_PERF_CNT_EN
      if (!ex_flush && !ex_hold && ref_haz(m)) m_bub++;
      if (ex_flush) m_fl++;
`endif
      m = ref_next(m);
      @(posedge clk); #1;
      check("rnd_ex", 256'(dut_ex()), 256'(m));
`ifdef HAZ_PERF_CNT_EN
      check("rnd_cnt", 256'({bubble_cnt, flush_cnt}), 256'({m_bub, m_fl}));
`endif
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
